fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction-fetch stage; the producer that drives the fetch/decode pipeline register.
- Keeps the PC and issues single-outstanding requests to instruction memory.
- Presents {next_pc, instr, valid} to the FD register.
- Honours the decode-side stall and applies redirects from execute.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- PC_STEP, 4, byte increment per sequential instruction.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- stall  in  Signal  ENABLE = FD register holding; outputs must not advance.
- redirect_valid_i  in  1  taken branch/jump this cycle.
- redirect_pc_i  in  ProgramCounter  new fetch address.
- imem_req_o  out  1  request valid.
- imem_addr_o  out  ProgramCounter  request address.
- imem_ready_i  in  1  memory accepts the request when high with imem_req_o.
- imem_rsp_valid_i  in  1  response data valid; arrives 1+ cycles after acceptance.
- imem_rsp_data_i  in  Instruction  fetched word.
- next_pc_o  out  ProgramCounter  PC of the presented instruction plus PC_STEP.
- instr_o  out  Instruction  presented instruction.
- instr_valid_o  out  1  instr_o is a real instruction (0 = bubble).

Behaviour:
- Reset values (rst low, asynchronous):
  - pc = RESET_PC; state = IDLE.
  - imem_req_o = 0; imem_addr_o = RESET_PC.
  - next_pc_o = RESET_PC; instr_o = NOP; instr_valid_o = 0.
  - skid buffer empty; drop flag clear.
- FSM states: IDLE, REQ, WAIT, FULL.
  - IDLE: one cycle after reset release, then REQ.
  - REQ: imem_req_o = 1, imem_addr_o = pc. imem_addr_o stays stable until imem_ready_i.
    - On accept: latch req_pc = pc; pc <= pc + PC_STEP; go to WAIT.
  - WAIT: on imem_rsp_valid_i, deliver the instruction (see below).
  - FULL: skid buffer holds an instruction. No request is issued. Leave when stall == DISABLE.
- Delivering a response:
  - If stall == DISABLE: register outputs load instr = rsp_data, next_pc = req_pc + PC_STEP, valid = 1. Go to REQ on the same edge, so back-to-back requests are possible.
  - If stall == ENABLE: capture into the 1-entry skid buffer; go to FULL.
- Output register:
  - Holds its value while stall == ENABLE.
  - If stall == DISABLE and no new instruction is available: load bubble (instr_o = NOP, valid = 0, next_pc_o unchanged).
- FULL exit (stall == DISABLE): skid contents move to the outputs; skid is cleared; go to REQ.
- Redirect (highest priority; overrides stall):
  - pc <= redirect_pc_i; skid cleared; outputs <= bubble next edge.
  - State goes to REQ, except in WAIT, where the drop flag is set and state stays WAIT.
  - A response with the drop flag set is discarded; drop flag clears; go to REQ.
  - Redirect in REQ before accept: the request is withdrawn. imem_addr_o shows redirect_pc_i from the next cycle.
  - Redirect in the same cycle as an accept: the accepted request is marked drop.
- Arithmetic: PC adds wrap modulo 2^32 with no flag; 32'hFFFF_FFFC + 4 = 0.
- Latency: without stall or memory delay, one instruction every 2 cycles (request, response). A response registers to the outputs on the edge of its arrival.
- At most one outstanding request. imem_rsp_valid_i outside WAIT is ignored.

Decomposition:
- Shared package additions:
  - NOP constant (32'h0000_0013).
  - FetchState enum {IDLE, REQ, WAIT, FULL}.
  - Reuse the existing ProgramCounter, Instruction and Signal typedefs.
- One natural sub-module: fetch_skid, a 1-entry instr/next_pc holding buffer with load, drain and clear.

Test Plan:
- Reset with imem_ready_i = 1, rsp one cycle after accept, stall = DISABLE.
  - -> Addresses 0, 4, 8 requested.
  - -> instr_o sequence matches memory; next_pc_o = 4, 8, 12; valid high on every response edge.
- stall = ENABLE for 5 cycles while a response arrives.
  - -> Outputs frozen; skid captures the word; no imem_req_o.
  - -> After release, the skid word appears with next_pc_o = its PC + 4, then fetch resumes.
- redirect_valid_i = 1, redirect_pc_i = 32'h100, while in WAIT.
  - -> The late response is dropped and the outputs show a bubble.
  - -> Next request address = 32'h100; the delivered instr has next_pc_o = 32'h104.
- imem_ready_i low for 3 cycles.
  - -> imem_req_o held high with a stable address; pc advances only on accept.
- rst asserted low mid-WAIT.
  - -> All outputs are reset immediately, without waiting for a clk edge.
  - -> After release, the first request goes to RESET_PC; the stale response is ignored.
- RESET_PC = 32'hFFFF_FFFC.
  - -> The second request address is 32'h0000_0000.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_unit_pkg;

  localparam int unsigned XLEN = 32;

  typedef logic [XLEN-1:0] program_counter_t;
  typedef logic [XLEN-1:0] instruction_t;

  typedef enum logic {
    DISABLE = 1'b0,
    ENABLE  = 1'b1
  } signal_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    FULL = 2'd3
  } fetch_state_e;

  localparam instruction_t NOP = 32'h0000_0013;

  // One fetch/decode payload entry.
  typedef struct packed {
    program_counter_t next_pc;
    instruction_t     instr;
  } fd_entry_t;

  // Wrapping PC increment.
  function automatic program_counter_t pc_add(input program_counter_t pc, input int unsigned step);
    return pc + program_counter_t'(step);
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bus between the fetch stage and imem.
interface fetch_unit_if;
  import fetch_unit_pkg::*;

  logic             imem_req_o;
  program_counter_t imem_addr_o;
  logic             imem_ready_i;
  logic             imem_rsp_valid_i;
  instruction_t     imem_rsp_data_i;

  modport master (
    output imem_req_o,
    output imem_addr_o,
    input  imem_ready_i,
    input  imem_rsp_valid_i,
    input  imem_rsp_data_i
  );

  modport slave (
    input  imem_req_o,
    input  imem_addr_o,
    output imem_ready_i,
    output imem_rsp_valid_i,
    output imem_rsp_data_i
  );

endinterface

// File: rtl/fetch_skid.sv
// One-entry holding buffer for a response that arrives while decode is stalled.
module fetch_skid
  import fetch_unit_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      load,
  input  fd_entry_t load_entry,
  input  logic      drain,
  input  logic      clear,
  output logic      full,
  output fd_entry_t entry
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      full  <= 1'b0;
      entry <= '{next_pc: '0, instr: NOP};
    end else if (clear || drain) begin
      full  <= 1'b0;
    end else if (load) begin
      full  <= 1'b1;
      entry <= load_entry;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues single-outstanding imem requests
// and drives the fetch/decode register with {next_pc, instr, valid}.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter program_counter_t RESET_PC = 32'h0000_0000,
  parameter int unsigned      PC_STEP  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  signal_e          stall,
  input  logic             redirect_valid_i,
  input  program_counter_t redirect_pc_i,
  fetch_unit_if.master     imem,
  output program_counter_t next_pc_o,
  output instruction_t     instr_o,
  output logic             instr_valid_o
);

  fetch_state_e     state;
  program_counter_t pc;
  program_counter_t req_pc;
  logic             drop;

  logic             accept_c;
  logic             rsp_c;
  logic             release_c;
  logic             skid_load_c;
  logic             skid_drain_c;
  logic             skid_full;
  fd_entry_t        skid_entry;
  fd_entry_t        rsp_entry_c;

  assign accept_c     = (state == REQ) && imem.imem_req_o && imem.imem_ready_i;
  assign rsp_c        = (state == WAIT) && imem.imem_rsp_valid_i;
  assign release_c    = !redirect_valid_i && (stall == DISABLE);
  assign skid_load_c  = rsp_c && !drop && !redirect_valid_i && (stall == ENABLE);
  assign skid_drain_c = (state == FULL) && release_c;
  assign rsp_entry_c  = '{next_pc: pc_add(req_pc, PC_STEP), instr: imem.imem_rsp_data_i};

  fetch_skid u_skid (
    .clk        (clk),
    .rst        (rst),
    .load       (skid_load_c),
    .load_entry (rsp_entry_c),
    .drain      (skid_drain_c),
    .clear      (redirect_valid_i),
    .full       (skid_full),
    .entry      (skid_entry)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state            <= IDLE;
      pc               <= RESET_PC;
      req_pc           <= RESET_PC;
      drop             <= 1'b0;
      imem.imem_req_o  <= 1'b0;
      imem.imem_addr_o <= RESET_PC;
      next_pc_o        <= RESET_PC;
      instr_o          <= NOP;
      instr_valid_o    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          state            <= REQ;
          imem.imem_req_o  <= 1'b1;
          imem.imem_addr_o <= pc;
        end
        REQ: begin
          if (accept_c) begin
            req_pc          <= pc;
            pc              <= pc_add(pc, PC_STEP);
            state           <= WAIT;
            imem.imem_req_o <= 1'b0;
          end
        end
        WAIT: begin
          if (rsp_c) begin
            if (drop || stall == DISABLE) begin
              drop             <= 1'b0;
              state            <= REQ;
              imem.imem_req_o  <= 1'b1;
              imem.imem_addr_o <= pc;
            end else begin
              state <= FULL;
            end
          end
        end
        FULL: begin
          if (stall == DISABLE) begin
            state            <= REQ;
            imem.imem_req_o  <= 1'b1;
            imem.imem_addr_o <= pc;
          end
        end
        default: state <= IDLE;
      endcase

      // Output register: fresh response, then skid, else bubble; holds under stall.
      if (stall == DISABLE) begin
        if (rsp_c && !drop) begin
          next_pc_o     <= rsp_entry_c.next_pc;
          instr_o       <= rsp_entry_c.instr;
          instr_valid_o <= 1'b1;
        end else if (state == FULL && skid_full) begin
          next_pc_o     <= skid_entry.next_pc;
          instr_o       <= skid_entry.instr;
          instr_valid_o <= 1'b1;
        end else begin
          instr_o       <= NOP;
          instr_valid_o <= 1'b0;
        end
      end

      // Redirect wins over everything; an in-flight request must still be drained.
      if (redirect_valid_i) begin
        pc            <= redirect_pc_i;
        instr_o       <= NOP;
        instr_valid_o <= 1'b0;
        if ((state == WAIT && !rsp_c) || accept_c) begin
          drop            <= 1'b1;
          state           <= WAIT;
          imem.imem_req_o <= 1'b0;
        end else begin
          drop             <= 1'b0;
          state            <= REQ;
          imem.imem_req_o  <= 1'b1;
          imem.imem_addr_o <= redirect_pc_i;
        end
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a latency-configurable imem model and an
// expected-instruction scoreboard.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  logic             clk = 1'b0;
  logic             rst;
  logic             rst2;
  signal_e          stall;
  logic             redirect_valid_i;
  program_counter_t redirect_pc_i;
  program_counter_t next_pc_o;
  instruction_t     instr_o;
  logic             instr_valid_o;
  program_counter_t next_pc2;
  instruction_t     instr2;
  logic             valid2;

  fetch_unit_if mif ();
  fetch_unit_if m2 ();

  fetch_unit dut (
    .clk              (clk),
    .rst              (rst),
    .stall            (stall),
    .redirect_valid_i (redirect_valid_i),
    .redirect_pc_i    (redirect_pc_i),
    .imem             (mif.master),
    .next_pc_o        (next_pc_o),
    .instr_o          (instr_o),
    .instr_valid_o    (instr_valid_o)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .PC_STEP(4)) dut2 (
    .clk              (clk),
    .rst              (rst2),
    .stall            (DISABLE),
    .redirect_valid_i (1'b0),
    .redirect_pc_i    (32'h0),
    .imem             (m2.master),
    .next_pc_o        (next_pc2),
    .instr_o          (instr2),
    .instr_valid_o    (valid2)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int lat = 1;
  int pend_cnt = 0;
  int delivered = 0;
  logic pend = 1'b0;
  logic acc_seen = 1'b0;
  logic chk_rv = 1'b0;
  logic got2 = 1'b0;
  program_counter_t pend_addr = '0;
  program_counter_t last_np = '0;
  program_counter_t first_np2 = '0;
  instruction_t first_instr2 = '0;
  program_counter_t acc_log[$];
  program_counter_t log2[$];
  fd_entry_t exp_q[$];

  function automatic instruction_t mem_word(input program_counter_t a);
    return (a ^ 32'h5A5A_0000) + 32'h0000_0101;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: memory models, scoreboard push, output monitor.
  task automatic tick();
    logic acc_pre, redir_pre, rsp_pre, rst_pre, acc2_pre;
    program_counter_t addr_pre, addr2_pre;
    fd_entry_t e;
    acc_pre   = mif.imem_req_o && mif.imem_ready_i;
    addr_pre  = mif.imem_addr_o;
    redir_pre = redirect_valid_i;
    rsp_pre   = mif.imem_rsp_valid_i;
    rst_pre   = rst;
    acc2_pre  = m2.imem_req_o && m2.imem_ready_i;
    addr2_pre = m2.imem_addr_o;
    @(posedge clk);
    #1;
    acc_seen = acc_pre && rst_pre;
    mif.imem_rsp_valid_i = 1'b0;
    mif.imem_rsp_data_i  = 32'hDEAD_BEEF;
    if (acc_seen) begin
      pend = 1'b1; pend_cnt = lat; pend_addr = addr_pre;
      acc_log.push_back(addr_pre);
      if (!redir_pre) exp_q.push_back('{next_pc: addr_pre + 32'd4, instr: mem_word(addr_pre)});
    end
    if (pend) begin
      if (pend_cnt <= 1) begin
        mif.imem_rsp_valid_i = 1'b1;
        mif.imem_rsp_data_i  = mem_word(pend_addr);
        pend = 1'b0;
      end else pend_cnt--;
    end
    if (redir_pre) exp_q.delete();
    if (rst_pre && rst) begin
      if (chk_rv && rsp_pre) check("rsp_edge_valid", 32'(instr_valid_o), 32'd1);
      if (instr_valid_o) begin
        if (exp_q.size() == 0) check("spurious_valid", 32'(instr_valid_o), 32'd0);
        else begin
          e = exp_q.pop_front();
          check("sb_instr", instr_o, e.instr);
          check("sb_next_pc", next_pc_o, e.next_pc);
          delivered++;
          last_np = e.next_pc;
        end
      end
    end
    if (acc2_pre && rst2) log2.push_back(addr2_pre);
    m2.imem_rsp_valid_i = acc2_pre && rst2;
    m2.imem_rsp_data_i  = acc2_pre ? mem_word(addr2_pre) : 32'hDEAD_BEEF;
    if (valid2 && !got2) begin
      got2 = 1'b1; first_np2 = next_pc2; first_instr2 = instr2;
    end
  endtask

  task automatic wait_accept(input string tag);
    int n = 0;
    acc_seen = 1'b0;
    while (!acc_seen && n < 40) begin tick(); n++; end
    check(tag, 32'(acc_seen), 32'd1);
  endtask

  task automatic run_until_delivered(input string tag, input int target);
    int n = 0;
    while (delivered < target && n < 60) begin tick(); n++; end
    check(tag, 32'(delivered), 32'(target));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req"}, 32'(mif.imem_req_o), 32'd0);
    check({tag, "_addr"}, mif.imem_addr_o, 32'h0);
    check({tag, "_next_pc"}, next_pc_o, 32'h0);
    check({tag, "_instr"}, instr_o, NOP);
    check({tag, "_valid"}, 32'(instr_valid_o), 32'd0);
  endtask

  initial begin
    int n_acc;
    rst = 1'b0; rst2 = 1'b0;
    stall = DISABLE;
    redirect_valid_i = 1'b0;
    redirect_pc_i = '0;
    mif.imem_ready_i = 1'b1;
    mif.imem_rsp_valid_i = 1'b0;
    mif.imem_rsp_data_i = 32'hDEAD_BEEF;
    m2.imem_ready_i = 1'b1;
    m2.imem_rsp_valid_i = 1'b0;
    m2.imem_rsp_data_i = 32'hDEAD_BEEF;
    tick(); tick();
    check_reset_outputs("reset");

    // Sequential fetch, zero memory delay.
    rst = 1'b1; rst2 = 1'b1; chk_rv = 1'b1;
    tick();
    check("first_req", 32'(mif.imem_req_o), 32'd1);
    check("first_addr", mif.imem_addr_o, 32'h0);
    run_until_delivered("seq_timeout", 3);
    chk_rv = 1'b0;
    check("seq_acc_count", 32'(acc_log.size()), 32'd3);
    if (acc_log.size() >= 3) begin
      check("seq_addr0", acc_log[0], 32'h0);
      check("seq_addr1", acc_log[1], 32'h4);
      check("seq_addr2", acc_log[2], 32'h8);
    end

    // Stall while the response for address 12 arrives.
    wait_accept("stall_accept_timeout");
    stall = ENABLE;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_valid", 32'(instr_valid_o), 32'd0);
      check("stall_instr", instr_o, NOP);
      check("stall_next_pc", next_pc_o, 32'hC);
      check("stall_no_req", 32'(mif.imem_req_o), 32'd0);
    end
    stall = DISABLE;
    tick();
    check("skid_valid", 32'(instr_valid_o), 32'd1);
    check("skid_next_pc", next_pc_o, 32'h10);
    check("resume_req", 32'(mif.imem_req_o), 32'd1);
    check("resume_addr", mif.imem_addr_o, 32'h10);

    // Redirect while waiting on a slow response.
    lat = 2;
    wait_accept("redir_accept_timeout");
    redirect_valid_i = 1'b1; redirect_pc_i = 32'h100;
    tick();
    redirect_valid_i = 1'b0;
    check("redir_bubble_valid", 32'(instr_valid_o), 32'd0);
    check("redir_bubble_instr", instr_o, NOP);
    tick();
    check("drop_valid", 32'(instr_valid_o), 32'd0);
    check("redir_req", 32'(mif.imem_req_o), 32'd1);
    check("redir_addr", mif.imem_addr_o, 32'h100);
    lat = 1;
    run_until_delivered("redir_timeout", delivered + 1);
    check("redir_next_pc", last_np, 32'h104);
    check("redir_acc_addr", acc_log[acc_log.size() - 1], 32'h100);

    // Memory not ready for three cycles.
    mif.imem_ready_i = 1'b0;
    n_acc = acc_log.size();
    for (int i = 0; i < 3; i++) begin
      tick();
      check("notready_req", 32'(mif.imem_req_o), 32'd1);
      check("notready_addr", mif.imem_addr_o, 32'h104);
    end
    mif.imem_ready_i = 1'b1;
    tick();
    check("ready_acc_count", 32'(acc_log.size()), 32'(n_acc + 1));
    check("ready_acc_addr", acc_log[acc_log.size() - 1], 32'h104);
    run_until_delivered("ready_timeout", delivered + 1);
    check("ready_next_addr", mif.imem_addr_o, 32'h108);

    // Asynchronous reset in WAIT; the stale response lands in IDLE.
    lat = 2;
    wait_accept("rst_accept_timeout");
    #2 rst = 1'b0;
    #1 check_reset_outputs("async_rst");
    exp_q.delete();
    tick();
    rst = 1'b1; lat = 1;
    acc_log.delete();
    tick();
    check("post_rst_stale_valid", 32'(instr_valid_o), 32'd0);
    check("post_rst_req", 32'(mif.imem_req_o), 32'd1);
    check("post_rst_addr", mif.imem_addr_o, 32'h0);
    run_until_delivered("post_rst_timeout", delivered + 1);
    check("post_rst_next_pc", last_np, 32'h4);

    // Wrap-around instance.
    check("wrap_acc_count", 32'(log2.size() >= 2), 32'd1);
    if (log2.size() >= 2) begin
      check("wrap_addr0", log2[0], 32'hFFFF_FFFC);
      check("wrap_addr1", log2[1], 32'h0);
    end
    check("wrap_first_valid", 32'(got2), 32'd1);
    check("wrap_next_pc", first_np2, 32'h0);
    check("wrap_instr", first_instr2, mem_word(32'hFFFF_FFFC));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
